tk1_spi_flash_ctrl: RTL and testbench

//  Command sequencer for the tk1 SPI master. It turns one API-programmed flash transaction into a byte sequence:

---
 rtl/tk1_spi_flash_ctrl_if.sv | 29 ++
 rtl/tk1_spi_flash_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_tk1_spi_flash_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tk1_spi_flash_ctrl_if.sv
// API bus and SPI-master handshake bundle for tk1_spi_flash_ctrl.
// "slave" is the controller view; "master" is the view of the API decoder plus SPI master.
interface tk1_spi_flash_ctrl_if;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        spi_enable;
    logic        spi_enable_we;
    logic        spi_start;
    logic [7:0]  spi_tx_data;
    logic        spi_tx_data_we;
    logic        spi_ready;
    logic [7:0]  spi_rx_data;

    modport slave (
        input  cs, we, address, write_data, spi_ready, spi_rx_data,
        output read_data, ready, spi_enable, spi_enable_we, spi_start, spi_tx_data,
        output spi_tx_data_we
    );

    modport master (
        output cs, we, address, write_data, spi_ready, spi_rx_data,
        input  read_data, ready, spi_enable, spi_enable_we, spi_start, spi_tx_data,
        input  spi_tx_data_we
    );
endinterface

// File: rtl/tk1_spi_flash_ctrl.sv
// Flash command sequencer: opcode, optional 24-bit address, LEN read bytes into an RX FIFO.
// Optional WIP status polling after the main transaction: `define SPI_FLASH_CTRL_POLL_EN.
module tk1_spi_flash_ctrl #(
    parameter int unsigned RX_DEPTH = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    tk1_spi_flash_ctrl_if.slave bus
);
    localparam int unsigned PtrW = $clog2(RX_DEPTH);
    localparam int unsigned LenW = PtrW + 1;
    localparam int unsigned IdxW = $clog2(RX_DEPTH + 5);

    typedef enum logic [2:0] {
        StIdle, StSsOn, StLoad, StStart, StSettle, StWait, StSsOff
    } state_e;

    state_e          state_q;
    logic [7:0]      cmd_q;
    logic [23:0]     addr_q;
    logic            addr_en_q;
    logic [LenW-1:0] len_q;
    logic            busy_q;
    logic            done_q;
    logic            abort_q;
    logic [IdxW-1:0] idx_q;
    logic            spi_enable_q;
    logic            spi_enable_we_q;
    logic            spi_start_q;
    logic [7:0]      spi_tx_data_q;
    logic            spi_tx_data_we_q;

    logic [7:0]      fifo_q [RX_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [LenW-1:0] level_q;

    logic            in_poll;
    logic            timeout;
`ifdef SPI_FLASH_CTRL_POLL_EN
    logic            poll_q;
    logic            in_poll_q;
    logic            wip_q;
    logic            timeout_q;
    logic [15:0]     poll_cnt_q;
    assign in_poll = in_poll_q;
    assign timeout = timeout_q;
`else
    assign in_poll = 1'b0;
    assign timeout = 1'b0;
`endif

    logic            wr_en;
    logic            cfg_we;
    logic            start_req;
    logic            push;
    logic            pop;
    logic            is_data;
    logic            is_last;
    logic [IdxW-1:0] hdr_len;
    logic [IdxW-1:0] last_idx;
    logic [IdxW-1:0] next_idx;
    logic [7:0]      tx_byte;

    always_comb begin
        wr_en     = bus.cs & bus.we;
        cfg_we    = wr_en & ~busy_q;
        start_req = wr_en && (bus.address == 8'h00) && bus.write_data[0] && (state_q == StIdle);
        hdr_len   = addr_en_q ? IdxW'(4) : IdxW'(1);
        last_idx  = in_poll ? IdxW'(1) : hdr_len + IdxW'(len_q) - IdxW'(1);
        is_data   = ~in_poll && (idx_q >= hdr_len);
        is_last   = (idx_q == last_idx);
        push      = (state_q == StWait) && bus.spi_ready && is_data;
        pop       = bus.cs && ~bus.we && (bus.address == 8'h05) && (level_q != '0);
        // SSON loads the first byte; WAIT loads the one after the byte just finished.
        next_idx  = (state_q == StSsOn) ? '0 : idx_q + IdxW'(1);
        tx_byte   = 8'h00;
        if (in_poll) begin
            tx_byte = (next_idx == '0) ? 8'h05 : 8'h00;
        end else if (next_idx == '0) begin
            tx_byte = cmd_q;
        end else if (addr_en_q) begin
            case (next_idx)
                IdxW'(1): tx_byte = addr_q[23:16];
                IdxW'(2): tx_byte = addr_q[15:8];
                IdxW'(3): tx_byte = addr_q[7:0];
                default:  tx_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            cmd_q            <= '0;
            addr_q           <= '0;
            addr_en_q        <= 1'b0;
            len_q            <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            abort_q          <= 1'b0;
            idx_q            <= '0;
            spi_enable_q     <= 1'b0;
            spi_enable_we_q  <= 1'b0;
            spi_start_q      <= 1'b0;
            spi_tx_data_q    <= '0;
            spi_tx_data_we_q <= 1'b0;
`ifdef SPI_FLASH_CTRL_POLL_EN
            poll_q           <= 1'b0;
            in_poll_q        <= 1'b0;
            wip_q            <= 1'b0;
            timeout_q        <= 1'b0;
            poll_cnt_q       <= '0;
`endif
        end else begin
            spi_enable_we_q  <= 1'b0;
            spi_tx_data_we_q <= 1'b0;
            spi_start_q      <= 1'b0;

            if (cfg_we) begin
                case (bus.address)
                    8'h01: cmd_q     <= bus.write_data[7:0];
                    8'h02: addr_q    <= bus.write_data[23:0];
                    8'h03: addr_en_q <= bus.write_data[0];
                    8'h04: len_q     <= (bus.write_data > 32'(RX_DEPTH)) ? LenW'(RX_DEPTH)
                                                                         : LenW'(bus.write_data);
                    default: ;
                endcase
            end
            if (wr_en && (bus.address == 8'h00) && bus.write_data[2] && busy_q) begin
                abort_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start_req) begin
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
                        abort_q         <= 1'b0;
                        idx_q           <= '0;
                        spi_enable_q    <= 1'b1;
                        spi_enable_we_q <= 1'b1;
                        state_q         <= StSsOn;
`ifdef SPI_FLASH_CTRL_POLL_EN
                        poll_q          <= bus.write_data[1];
                        in_poll_q       <= 1'b0;
                        wip_q           <= 1'b0;
                        timeout_q       <= 1'b0;
                        poll_cnt_q      <= '0;
`endif
                    end
                end
                StSsOn: begin
                    idx_q            <= '0;
                    spi_tx_data_q    <= tx_byte;
                    spi_tx_data_we_q <= 1'b1;
                    state_q          <= StLoad;
                end
                StLoad: begin
                    spi_start_q <= 1'b1;
                    state_q     <= StStart;
                end
                StStart:  state_q <= StSettle;
                StSettle: state_q <= StWait;
                StWait: begin
                    if (bus.spi_ready) begin
`ifdef SPI_FLASH_CTRL_POLL_EN
                        if (in_poll_q && (idx_q == IdxW'(1))) wip_q <= bus.spi_rx_data[0];
`endif
                        if (is_last || abort_q) begin
                            spi_enable_q    <= 1'b0;
                            spi_enable_we_q <= 1'b1;
                            state_q         <= StSsOff;
                        end else begin
                            idx_q            <= next_idx;
                            spi_tx_data_q    <= tx_byte;
                            spi_tx_data_we_q <= 1'b1;
                            state_q          <= StLoad;
                        end
                    end
                end
                StSsOff: begin
`ifdef SPI_FLASH_CTRL_POLL_EN
                    // Poll once after the main transaction, then again while WIP stays set.
                    if (poll_q && !abort_q &&
                        (!in_poll_q || (wip_q && (poll_cnt_q != 16'hFFFF)))) begin
                        in_poll_q       <= 1'b1;
                        poll_cnt_q      <= poll_cnt_q + 16'd1;
                        idx_q           <= '0;
                        spi_enable_q    <= 1'b1;
                        spi_enable_we_q <= 1'b1;
                        state_q         <= StSsOn;
                    end else begin
                        timeout_q <= in_poll_q & wip_q & (poll_cnt_q == 16'hFFFF);
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= StIdle;
                    end
`else
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (start_req) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      level_q <= level_q + LenW'(1);
            else if (pop && !push) level_q <= level_q - LenW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= bus.spi_rx_data;
    end

    always_comb begin
        bus.read_data = '0;
        case (bus.address)
            8'h00: bus.read_data = {29'd0, timeout, done_q, busy_q};
            8'h01: bus.read_data = {24'd0, cmd_q};
            8'h02: bus.read_data = {8'd0, addr_q};
            8'h03: bus.read_data = {31'd0, addr_en_q};
            8'h04: bus.read_data = 32'(len_q);
            8'h05: bus.read_data = (level_q == '0) ? 32'd0 : {24'd0, fifo_q[rd_ptr_q]};
            8'h06: bus.read_data = 32'(level_q);
            default: bus.read_data = '0;
        endcase
    end

    assign bus.ready          = bus.cs;
    assign bus.spi_enable     = spi_enable_q;
    assign bus.spi_enable_we  = spi_enable_we_q;
    assign bus.spi_start      = spi_start_q;
    assign bus.spi_tx_data    = spi_tx_data_q;
    assign bus.spi_tx_data_we = spi_tx_data_we_q;
endmodule

// File: tb/tb_tk1_spi_flash_ctrl.sv
// Bench for tk1_spi_flash_ctrl: SPI master model, expected byte lists and FIFO contents
// built from the command/address/length rules.
module tb_tk1_spi_flash_ctrl;
    localparam int unsigned Depth = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tk1_spi_flash_ctrl_if bus ();

    tk1_spi_flash_ctrl #(.RX_DEPTH(Depth)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int slow = 0;
    byte unsigned tx_log[$];
    byte unsigned rx_sent[$];
    byte unsigned resp_q[$];
    bit en_log[$];

    // SPI master model: logs loads/enables, answers each start after a few cycles.
    initial begin
        bus.spi_ready = 1'b1;
        bus.spi_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.spi_tx_data_we) tx_log.push_back(bus.spi_tx_data);
            if (bus.spi_enable_we) en_log.push_back(bus.spi_enable);
            if (bus.spi_start) begin
                byte unsigned r;
                int d;
                r = (resp_q.size() != 0) ? resp_q.pop_front() : 8'($urandom_range(0, 255));
                d = (slow != 0) ? 7 : int'($urandom_range(3, 6));
                bus.spi_ready = 1'b0;
                bus.spi_rx_data = ~r;
                repeat (d - 1) @(negedge clk);
                bus.spi_rx_data = r;
                bus.spi_ready = 1'b1;
                rx_sent.push_back(r);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.address = a; bus.write_data = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.address = a;
        #1 d = bus.read_data;
        @(negedge clk);
        bus.cs = 1'b0;
    endtask

    task automatic wait_idle();
        logic [31:0] v;
        int k;
        k = 0;
        do begin
            rd(8'h00, v);
            k++;
        end while (v[0] && k < 3000);
        check("wait_idle busy", {31'd0, v[0]}, 32'd0);
    endtask

    task automatic clear_logs();
        tx_log.delete(); en_log.delete(); rx_sent.delete();
    endtask

    // One full transaction compared against the byte list built from cmd/addr/len.
    task automatic run_txn(input string tag, input logic [7:0] cmd, input logic [23:0] addr,
                           input bit aen, input int len);
        byte unsigned exp_tx[$];
        logic [31:0] v;
        int hdr;
        exp_tx.push_back(cmd);
        if (aen) begin
            exp_tx.push_back(addr[23:16]);
            exp_tx.push_back(addr[15:8]);
            exp_tx.push_back(addr[7:0]);
        end
        hdr = exp_tx.size();
        repeat (len) exp_tx.push_back(8'h00);
        clear_logs();
        wr(8'h01, {24'd0, cmd});
        wr(8'h02, {8'd0, addr});
        wr(8'h03, {31'd0, aen});
        wr(8'h04, 32'(len));
        wr(8'h00, 32'd1);
        wait_idle();
        check({tag, " tx count"}, 32'(tx_log.size()), 32'(exp_tx.size()));
        foreach (exp_tx[i]) begin
            check($sformatf("%s tx[%0d]", tag, i),
                  (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF_FFFF, 32'(exp_tx[i]));
        end
        check({tag, " enable writes"}, 32'(en_log.size()), 32'd2);
        check({tag, " enables"}, {30'd0, en_log[0], en_log[1]}, 32'b10);
        rd(8'h06, v);
        check({tag, " level"}, v, 32'(len));
        for (int i = 0; i < len; i++) begin
            rd(8'h05, v);
            check($sformatf("%s rx[%0d]", tag, i), v, 32'(rx_sent[hdr + i]));
        end
        rd(8'h05, v);
        check({tag, " empty pop"}, v, 32'd0);
        rd(8'h00, v);
        check({tag, " ctrl"}, v, 32'b010);
    endtask

    initial begin
        logic [31:0] v;
        byte unsigned got[$];
        int k;
        bus.cs = 1'b0; bus.we = 1'b0; bus.address = '0; bus.write_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset outputs", {23'd0, bus.spi_enable, bus.spi_enable_we, bus.spi_start,
              bus.spi_tx_data_we, bus.spi_tx_data}, 32'd0);
        reset_n = 1'b1;
        rd(8'h00, v); check("reset ctrl", v, 32'd0);
        rd(8'h06, v); check("reset level", v, 32'd0);
        rd(8'h04, v); check("reset len", v, 32'd0);
        rd(8'h07, v); check("unmapped", v, 32'd0);

        // JEDEC ID read
        resp_q = '{8'h00, 8'hEF, 8'h40, 8'h18};
        run_txn("t1", 8'h9F, 24'h0, 1'b0, 3);
        check("t1 id order", {8'd0, rx_sent[1], rx_sent[2], rx_sent[3]}, 32'h00EF4018);

        run_txn("t2", 8'h03, 24'h123456, 1'b1, 2);

        // LEN saturation and LEN=0
        wr(8'h04, 32'd40); rd(8'h04, v); check("len sat 40", v, 32'(Depth));
        wr(8'h04, 32'd17); rd(8'h04, v); check("len sat 17", v, 32'(Depth));
        wr(8'h04, 32'd5);  rd(8'h04, v); check("len 5", v, 32'd5);
        run_txn("len0", 8'h0B, 24'hABCDEF, 1'b1, 0);
        run_txn("full", 8'h3B, 24'h00FF00, 1'b1, Depth);

        for (int t = 0; t < 4; t++) begin
            run_txn($sformatf("rand%0d", t), 8'($urandom_range(0, 255)),
                    24'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, Depth)));
        end

        // Pops while the FIFO is filling; order of all popped bytes must match
        clear_logs(); got.delete();
        wr(8'h02, 32'd0); wr(8'h03, 32'd0); wr(8'h04, 32'(Depth)); wr(8'h00, 32'd1);
        k = 0;
        do begin
            rd(8'h06, v);
            if (v != 0) begin
                rd(8'h05, v);
                got.push_back(v[7:0]);
            end
            rd(8'h00, v);
            k++;
        end while (v[0] && k < 2000);
        forever begin
            rd(8'h06, v);
            if (v == 0) break;
            rd(8'h05, v);
            got.push_back(v[7:0]);
        end
        check("concurrent count", 32'(got.size()), 32'(Depth));
        foreach (got[i]) check($sformatf("concurrent rx[%0d]", i), 32'(got[i]),
                               32'(rx_sent[1 + i]));

        // Abort during byte 6 (second data byte), with a start issued while busy
        slow = 1; clear_logs();
        wr(8'h01, 32'h3B); wr(8'h02, 32'h000100); wr(8'h03, 32'd1); wr(8'h04, 32'd8);
        wr(8'h00, 32'd1);
        k = 0;
        while (tx_log.size() < 6 && k < 500) begin @(negedge clk); k++; end
        wr(8'h00, 32'd1);
        wr(8'h00, 32'd4);
        wr(8'h01, 32'h77);
        wait_idle();
        repeat (20) @(negedge clk);
        check("abort tx count", 32'(tx_log.size()), 32'd6);
        check("abort enable writes", 32'(en_log.size()), 32'd2);
        rd(8'h06, v); check("abort level", v, 32'd2);
        rd(8'h00, v); check("abort ctrl", v, 32'b010);
        rd(8'h01, v); check("cmd write while busy", v, 32'h3B);
        rd(8'h05, v); check("abort rx0", v, 32'(rx_sent[4]));
        rd(8'h05, v); check("abort rx1", v, 32'(rx_sent[5]));
        wr(8'h00, 32'd4);
        rd(8'h00, v); check("abort idle", v, 32'b010);
        slow = 0;

`ifdef SPI_FLASH_CTRL_POLL_EN
        // Status polling: WIP 1,1,0
        clear_logs();
        resp_q = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'hFE};
        wr(8'h01, 32'h06); wr(8'h03, 32'd0); wr(8'h04, 32'd0); wr(8'h00, 32'd3);
        wait_idle();
        check("poll tx count", 32'(tx_log.size()), 32'd7);
        for (int i = 1; i < 7 && i < tx_log.size(); i++) begin
            check($sformatf("poll tx[%0d]", i), 32'(tx_log[i]), (i % 2 == 1) ? 32'h05 : 32'h00);
        end
        check("poll enable writes", 32'(en_log.size()), 32'd8);
        rd(8'h00, v); check("poll ctrl", v, 32'b010);
`endif

        // Asynchronous reset in WAIT
        slow = 1; clear_logs();
        wr(8'h03, 32'd0); wr(8'h04, 32'd4); wr(8'h00, 32'd1);
        k = 0;
        while (tx_log.size() < 2 && k < 500) begin @(negedge clk); k++; end
        repeat (4) @(negedge clk);
        check("pre-reset ss", {31'd0, bus.spi_enable}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check("async reset outputs", {23'd0, bus.spi_enable, bus.spi_enable_we, bus.spi_start,
                 bus.spi_tx_data_we, bus.spi_tx_data}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd(8'h00, v); check("post-reset ctrl", v, 32'd0);
        rd(8'h06, v); check("post-reset level", v, 32'd0);
        slow = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
